sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Responder end of the decoupled memory request/response interface: it accepts `mem_req` transactions and executes them on one 32-bit asynchronous SRAM chip (1M x 32).
- Read data is returned on `mem_resp`.
- Sits below the CPU memory port as the board-level memory controller. One transaction is in flight at a time.

Parameters:
- BASE_ADDR, 32'h80000000: start of the 4 MiB window served; only bits [31:22] are compared.
- ADDR_WIDTH, 32: request address width.
- DATA_WIDTH, 32: data width; only 32 is supported.
- SRAM_AW, 20: SRAM word-address width.
- WAIT_CYCLES, 2: number of SRAM access-strobe cycles; must be >= 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req_addr  in  32  byte address.
- mem_req_we  in  1  1 = write.
- mem_req_data  in  32  write data.
- mem_req_be  in  4  byte enables, active high.
- mem_req_valid  in  1  request valid.
- mem_req_ready  out  1  request accepted when valid & ready.
- mem_resp_data  out  32  read data.
- mem_resp_valid  out  1  response valid.
- mem_resp_ready  in  1  requester accepts the response.
- sram_addr  out  20  SRAM word address.
- sram_d_o  out  32  data driven to the SRAM.
- sram_d_oe  out  1  output enable for the pad tristate (1 = drive `sram_d_o`).
- sram_d_i  in  32  data read from the SRAM.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_be_n  out  4  byte enables, active low.

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - state = IDLE, wait counter = 0.
  - `sram_ce_n`/`sram_oe_n`/`sram_we_n` = 1, `sram_be_n` = 4'hF, `sram_d_oe` = 0.
  - `sram_addr` = 0, `sram_d_o` = 0.
  - `mem_resp_valid` = 0, `mem_resp_data` = 0.
- `mem_req_ready` = (state == IDLE), combinational. It therefore reads 1 during and immediately after reset.
- Accept happens on valid & ready in IDLE:
  - Latch addr[21:2] into `sram_addr`, plus data, be and we.
  - hit = (addr[31:22] == BASE_ADDR[31:22]).
- State IDLE, on accept:
  - hit read -> SETUP.
  - hit write with be != 0 -> SETUP.
  - hit write with be == 0 -> stay IDLE (dropped, no SRAM cycle).
  - miss read -> RESP with `mem_resp_data` = 0.
  - miss write -> stay IDLE (dropped silently).
- State SETUP (1 cycle):
  - `sram_ce_n` = 0.
  - Read: `sram_oe_n` = 0, `sram_be_n` = 0.
  - Write: `sram_d_oe` = 1, `sram_d_o` = data, `sram_be_n` = ~be, `sram_we_n` = 1.
  - Load counter = WAIT_CYCLES-1 -> ACCESS.
- State ACCESS (WAIT_CYCLES cycles):
  - Controls as in SETUP, plus `sram_we_n` = 0 for writes.
  - Counter decrements each cycle.
  - At counter == 0: a read registers `sram_d_i` into `mem_resp_data` and goes to RESP; a write goes to HOLD.
- State HOLD (write only, 1 cycle):
  - `sram_we_n` = 1, `sram_ce_n` = 0, `sram_d_oe` = 1, data and address held (hold time).
  - -> IDLE.
- State RESP:
  - `mem_resp_valid` = 1; `mem_resp_data` is stable.
  - When `mem_resp_ready` = 1: clear valid and go to IDLE.
  - Back-pressure is unbounded.
- Writes never produce a response.
- Read latency: accept at cycle 0 -> `mem_resp_valid` high at cycle 2+WAIT_CYCLES.
- Minimum spacing between accepts:
  - Read: 3+WAIT_CYCLES cycles with ready held high.
  - Write: 3+WAIT_CYCLES cycles.
- `sram_d_oe` and `sram_oe_n` = 0 are never asserted in the same cycle.
- `sram_ce_n`/`sram_oe_n`/`sram_we_n`/`sram_be_n`/`sram_d_oe` are registered outputs, glitch-free.
- Outside SETUP/ACCESS/HOLD:
  - `sram_ce_n` = `sram_oe_n` = `sram_we_n` = 1, `sram_be_n` = 4'hF, `sram_d_oe` = 0.
  - `sram_addr` holds its last value.
- Reset mid-transaction: the SRAM is released asynchronously (strobes high, `sram_d_oe` = 0) and any pending response is lost. No request is accepted until `rst` deasserts.
- `mem_req_*` inputs are ignored outside IDLE; the requester must hold them while ready is low.

Test Plan:
- Read at 32'h80000010 (WAIT_CYCLES=2), SRAM model returns 32'hCAFEBABE -> `sram_addr` = 20'h4, `sram_oe_n` low for cycles 1-3, `mem_resp_valid` at cycle 4 with data 32'hCAFEBABE.
- Write 32'h11223344 to 32'h803FFFFC, be = 4'b0101 -> `sram_addr` = 20'hFFFFF, `sram_be_n` = 4'b1010, `sram_we_n` low exactly cycles 2-3, `sram_d_oe` high cycles 1-4, no response, ready back at cycle 5.
- Read with `mem_resp_ready` held 0 for 10 cycles -> valid and data stay stable, `mem_req_ready` stays 0, and the next request is accepted the cycle after the handshake.
- Read 32'h90000000 -> no SRAM strobes, response data 0 at cycle 1. Write 32'h00000000 -> dropped, ready stays 1. Write with be = 0 in window -> no strobes.
- Reset pulse in ACCESS of a write -> strobes go high and `sram_d_oe` = 0 in the same cycle, `mem_resp_valid` = 0, and a subsequent read is served correctly.
- Back-to-back alternating write/read to the same address (10 pairs, random data/be) -> each read returns the byte-merged expected value.

Source files
------------

// File: rtl/sram_responder.sv
`timescale 1ns/1ps
// sram_responder: responder end of the mem_req/mem_resp interface, driving one
// 1M x 32 asynchronous SRAM. One transaction is in flight at a time. Every SRAM
// strobe is taken straight from a flop so the pins never glitch.
module sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          SRAM_AW     = 20,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_req_we,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [DATA_WIDTH/8-1:0] mem_req_be,
  input  logic                    mem_req_valid,
  output logic                    mem_req_ready,
  output logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic                    mem_resp_valid,
  input  logic                    mem_resp_ready,
  output logic [SRAM_AW-1:0]      sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_d_o,
  output logic                    sram_d_oe,
  input  logic [DATA_WIDTH-1:0]   sram_d_i,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [DATA_WIDTH/8-1:0] sram_be_n
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               we_q, we_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] d_o_q, d_o_d;
  logic               d_oe_q, d_oe_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic [BE_W-1:0]    be_n_q, be_n_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic               resp_valid_q, resp_valid_d;

  logic               accept;
  logic               hit;
  logic               cur_we;
  logic [BE_W-1:0]    cur_be;
  logic               unused_addr_bits;

  // Byte lanes below the word address carry no information for a 32-bit SRAM.
  assign unused_addr_bits = ^mem_req_addr[1:0];

  assign mem_req_ready = (state_q == ST_IDLE);
  assign accept        = mem_req_valid && mem_req_ready;
  assign hit           = (mem_req_addr[31:22] == BASE_ADDR[31:22]);

  // Strobes for SETUP are registered on the accept edge, before the request
  // has been latched, so the live request is used while still in IDLE.
  assign cur_we = (state_q == ST_IDLE) ? mem_req_we : we_q;
  assign cur_be = (state_q == ST_IDLE) ? mem_req_be : be_q;

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: route each accepted request and sequence the SRAM cycle.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hit && (!mem_req_we || (mem_req_be != '0))) state_d = ST_SETUP;
          else if (!hit && !mem_req_we)                   state_d = ST_RESP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
      end
      ST_ACCESS: begin
        if (cnt_q == '0) state_d = we_q ? ST_HOLD : ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_HOLD: state_d = ST_IDLE;
      ST_RESP: if (mem_resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: derive next register values for the SRAM pins and response.
  always_comb begin
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    d_o_d        = d_o_q;
    ce_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    be_n_d       = '1;
    d_oe_d       = 1'b0;
    resp_data_d  = resp_data_q;
    resp_valid_d = (state_d == ST_RESP);

    if (accept) begin
      we_d   = mem_req_we;
      be_d   = mem_req_be;
      addr_d = mem_req_addr[SRAM_AW+1:2];
      if (mem_req_we) d_o_d = mem_req_data;
      if (!hit && !mem_req_we) resp_data_d = '0;
    end

    if ((state_q == ST_ACCESS) && (cnt_q == '0) && !we_q) resp_data_d = sram_d_i;

    case (state_d)
      ST_SETUP, ST_ACCESS: begin
        ce_n_d = 1'b0;
        if (cur_we) begin
          d_oe_d = 1'b1;
          be_n_d = ~cur_be;
          we_n_d = (state_d != ST_ACCESS);
        end else begin
          oe_n_d = 1'b0;
          be_n_d = '0;
        end
      end
      ST_HOLD: begin
        ce_n_d = 1'b0;
        d_oe_d = 1'b1;
        be_n_d = ~be_q;
      end
      default: ;
    endcase
  end

  // Output and transaction registers; reset releases the SRAM immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      d_o_q        <= '0;
      d_oe_q       <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      be_n_q       <= '1;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      d_o_q        <= d_o_d;
      d_oe_q       <= d_oe_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      be_n_q       <= be_n_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign sram_addr      = addr_q;
  assign sram_d_o       = d_o_q;
  assign sram_d_oe      = d_oe_q;
  assign sram_ce_n      = ce_n_q;
  assign sram_oe_n      = oe_n_q;
  assign sram_we_n      = we_n_q;
  assign sram_be_n      = be_n_q;
  assign mem_resp_data  = resp_data_q;
  assign mem_resp_valid = resp_valid_q;

endmodule

// File: tb/tb_sram_responder.sv
`timescale 1ns/1ps
// tb_sram_responder: behavioural SRAM, request-level reference memory feeding a
// response scoreboard, a vector table plus cycle-traced corner sequences.
module tb_sram_responder;

  localparam int W = 2;  // WAIT_CYCLES of the instance

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_req_addr = '0;
  logic        mem_req_we = 1'b0;
  logic [31:0] mem_req_data = '0;
  logic [3:0]  mem_req_be = '0;
  logic        mem_req_valid = 1'b0;
  logic        mem_req_ready;
  logic [31:0] mem_resp_data;
  logic        mem_resp_valid;
  logic        mem_resp_ready = 1'b1;
  logic [19:0] sram_addr;
  logic [31:0] sram_d_o;
  logic        sram_d_oe;
  logic [31:0] sram_d_i = '0;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  always #5 clk = ~clk;

  sram_responder #(
    .BASE_ADDR(32'h8000_0000), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .SRAM_AW(20), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_data(mem_req_data), .mem_req_be(mem_req_be),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_resp_data(mem_resp_data), .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready),
    .sram_addr(sram_addr), .sram_d_o(sram_d_o), .sram_d_oe(sram_d_oe),
    .sram_d_i(sram_d_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- SRAM model ----------------
  logic [31:0] sram_mem [logic [19:0]];
  logic [31:0] ref_mem  [logic [19:0]];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] dflt(input logic [19:0] a);
    return {12'h5A5, a};
  endfunction

  // Read data is presented mid-cycle from whatever the strobes select.
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_oe_n)
      sram_d_i = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : dflt(sram_addr);
    else
      sram_d_i = 32'hDEAD_BEEF;
  end

  // Byte-lane write while chip and write enable are both low.
  always @(posedge clk) begin
    if (rst && !sram_ce_n && !sram_we_n && sram_d_oe) begin
      logic [31:0] w;
      w = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : dflt(sram_addr);
      for (int b = 0; b < 4; b++) if (!sram_be_n[b]) w[8*b +: 8] = sram_d_o[8*b +: 8];
      sram_mem[sram_addr] = w;
    end
  end

  // ---------------- monitors ----------------
  int resp_seen = 0;
  int strobe_cycles = 0;

  always @(negedge clk) begin
    if (rst && mem_resp_valid && mem_resp_ready) begin
      resp_seen++;
      if (exp_q.size() == 0) check("resp_unexpected", {31'b0, mem_resp_valid}, 32'd0);
      else                   check("resp_data", mem_resp_data, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!sram_ce_n) strobe_cycles++;
    check("oe_contention", {31'b0, sram_d_oe & ~sram_oe_n}, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  task automatic model_accept(input logic [31:0] a, input logic we,
                              input logic [31:0] d, input logic [3:0] be);
    logic [19:0] wa;
    logic [31:0] w;
    logic        h;
    wa = a[21:2];
    h  = (a[31:22] == 10'h200);
    w  = ref_mem.exists(wa) ? ref_mem[wa] : dflt(wa);
    if (we) begin
      if (h) begin
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[wa] = w;
      end
    end else begin
      exp_q.push_back(h ? w : 32'h0);
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic we,
                           input logic [31:0] d, input logic [3:0] be);
    mem_req_addr  = a;
    mem_req_we    = we;
    mem_req_data  = d;
    mem_req_be    = be;
    mem_req_valid = 1'b1;
  endtask

  task automatic issue(input logic [31:0] a, input logic we,
                       input logic [31:0] d, input logic [3:0] be);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    drive_req(a, we, d, be);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (mem_req_ready) ok = 1'b1;
    end
    check("req_accept", {31'b0, ok}, 32'd1);
    if (ok) model_accept(a, we, d, be);
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && mem_req_ready) done = 1'b1;
    end
    check({name, "_idle"}, {31'b0, done}, 32'd1);
  endtask

  // ---------------- cycle trace ----------------
  logic [15:0] tv_ce, tv_oe, tv_we, tv_doe, tv_rv, tv_rdy;
  logic [19:0] tv_addr1;
  logic [3:0]  tv_ben2;

  task automatic sample(input int k);
    tv_ce[k]  = ~sram_ce_n;
    tv_oe[k]  = ~sram_oe_n;
    tv_we[k]  = ~sram_we_n;
    tv_doe[k] = sram_d_oe;
    tv_rv[k]  = mem_resp_valid;
    tv_rdy[k] = mem_req_ready;
    if (k == 1) tv_addr1 = sram_addr;
    if (k == 2) tv_ben2  = sram_be_n;
  endtask

  // Cycle 0 is the cycle in which the request is accepted.
  task automatic trace_txn(input logic [31:0] a, input logic we,
                           input logic [31:0] d, input logic [3:0] be, input int n);
    {tv_ce, tv_oe, tv_we, tv_doe, tv_rv, tv_rdy} = '0;
    tv_addr1 = '0;
    tv_ben2  = '0;
    @(posedge clk); #1;
    drive_req(a, we, d, be);
    @(negedge clk);
    sample(0);
    model_accept(a, we, d, be);
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      sample(k);
    end
  endtask

  function automatic logic [31:0] span(input int lo, input int hi);
    logic [31:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
    logic        exp_sram;  // an SRAM cycle must occur
    logic        exp_resp;  // a response must be returned
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          s0, r0;
    logic [31:0] a, d;
    logic [3:0]  be;
    bit          found, stable, rdy_low;
    logic [31:0] d0;

    vecs[0] = '{32'h8000_0040, 1'b1, 32'hA1B2_C3D4, 4'hF,    1'b1, 1'b0};
    vecs[1] = '{32'h8000_0040, 1'b0, 32'h0,        4'hF,    1'b1, 1'b1};
    vecs[2] = '{32'h8000_0040, 1'b1, 32'h0000_0000, 4'b1000, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0040, 1'b0, 32'h0,        4'hF,    1'b1, 1'b1};
    vecs[4] = '{32'h7FFF_FFFC, 1'b0, 32'h0,        4'hF,    1'b0, 1'b1};
    vecs[5] = '{32'hC000_0000, 1'b1, 32'h1234_5678, 4'hF,    1'b0, 1'b0};
    vecs[6] = '{32'h8000_0044, 1'b1, 32'hFFFF_FFFF, 4'h0,    1'b0, 1'b0};
    vecs[7] = '{32'h8000_0044, 1'b0, 32'h0,        4'hF,    1'b1, 1'b1};

    sram_mem[20'h4] = 32'hCAFE_BABE;
    ref_mem[20'h4]  = 32'hCAFE_BABE;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, mem_req_ready}, 32'd1);
    check("rst_strobes", {25'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_d_oe},
          {25'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0});
    check("rst_resp_valid", {31'b0, mem_resp_valid}, 32'd0);
    check("rst_resp_data", mem_resp_data, 32'd0);
    check("rst_sram_addr", {12'b0, sram_addr}, 32'd0);
    check("rst_sram_d_o", sram_d_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Traced read in the window
    trace_txn(32'h8000_0010, 1'b0, 32'h0, 4'hF, 8);
    check("rd_addr", {12'b0, tv_addr1}, 32'h4);
    check("rd_oe", {16'b0, tv_oe}, span(1, 1 + W));
    check("rd_ce", {16'b0, tv_ce}, span(1, 1 + W));
    check("rd_doe", {16'b0, tv_doe}, 32'd0);
    check("rd_resp_valid", {16'b0, tv_rv}, span(2 + W, 2 + W));
    check("rd_ready", {16'b0, tv_rdy}, span(0, 0) | span(3 + W, 7));
    wait_idle("rd");

    // Traced write at the top of the window
    trace_txn(32'h803F_FFFC, 1'b1, 32'h1122_3344, 4'b0101, 8);
    check("wr_addr", {12'b0, tv_addr1}, 32'hF_FFFF);
    check("wr_be_n", {28'b0, tv_ben2}, 32'hA);
    check("wr_we", {16'b0, tv_we}, span(2, 1 + W));
    check("wr_doe", {16'b0, tv_doe}, span(1, 2 + W));
    check("wr_ce", {16'b0, tv_ce}, span(1, 2 + W));
    check("wr_oe", {16'b0, tv_oe}, 32'd0);
    check("wr_resp_valid", {16'b0, tv_rv}, 32'd0);
    check("wr_ready", {16'b0, tv_rdy}, span(0, 0) | span(3 + W, 7));
    issue(32'h803F_FFFC, 1'b0, 32'h0, 4'hF);
    wait_idle("wr_readback");

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      s0 = strobe_cycles;
      r0 = resp_seen;
      issue(vecs[i].addr, vecs[i].we, vecs[i].data, vecs[i].be);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_sram", i), {31'b0, strobe_cycles > s0}, {31'b0, vecs[i].exp_sram});
      check($sformatf("vec%0d_resp", i), resp_seen - r0, {31'b0, vecs[i].exp_resp});
    end

    // Out-of-window read, dropped out-of-window write, empty-byte-enable write
    trace_txn(32'h9000_0000, 1'b0, 32'h0, 4'hF, 4);
    check("miss_rd_resp_valid", {16'b0, tv_rv}, span(1, 1));
    check("miss_rd_ce", {16'b0, tv_ce}, 32'd0);
    check("miss_rd_ready", {16'b0, tv_rdy}, span(0, 0) | span(2, 3));
    wait_idle("miss_rd");
    trace_txn(32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 4);
    check("miss_wr_ce", {16'b0, tv_ce}, 32'd0);
    check("miss_wr_ready", {16'b0, tv_rdy}, span(0, 3));
    check("miss_wr_resp_valid", {16'b0, tv_rv}, 32'd0);
    trace_txn(32'h8000_0020, 1'b1, 32'hFFFF_FFFF, 4'h0, 4);
    check("be0_wr_ce", {16'b0, tv_ce}, 32'd0);
    check("be0_wr_ready", {16'b0, tv_rdy}, span(0, 3));

    // Response back-pressure for 10 cycles, then a request queued behind it
    mem_resp_ready = 1'b0;
    issue(32'h8000_0010, 1'b0, 32'h0, 4'hF);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (mem_resp_valid) found = 1'b1;
    end
    check("bp_valid_seen", {31'b0, found}, 32'd1);
    d0      = mem_resp_data;
    stable  = 1'b1;
    rdy_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!mem_resp_valid || mem_resp_data !== d0) stable = 1'b0;
      if (mem_req_ready) rdy_low = 1'b0;
    end
    check("bp_stable", {31'b0, stable}, 32'd1);
    check("bp_ready_low", {31'b0, rdy_low}, 32'd1);
    check("bp_data", d0, 32'hCAFE_BABE);
    @(posedge clk); #1;
    mem_resp_ready = 1'b1;
    drive_req(32'h8000_0040, 1'b0, 32'h0, 4'hF);
    model_accept(32'h8000_0040, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    check("bp_ready_at_hs", {31'b0, mem_req_ready}, 32'd0);
    @(negedge clk);
    check("bp_ready_after_hs", {31'b0, mem_req_ready}, 32'd1);
    check("bp_valid_after_hs", {31'b0, mem_resp_valid}, 32'd0);
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    @(negedge clk);
    check("bp_next_accepted", {31'b0, mem_req_ready}, 32'd0);
    wait_idle("bp");

    // Reset pulse while a write is in ACCESS
    @(posedge clk); #1;
    drive_req(32'h8000_0100, 1'b1, 32'h55AA_55AA, 4'hF);
    @(negedge clk);
    check("rstmid_accept", {31'b0, mem_req_ready}, 32'd1);
    @(posedge clk); #1;
    mem_req_valid = 1'b0;
    @(posedge clk); #2;
    check("rstmid_in_access", {31'b0, sram_we_n}, 32'd0);
    rst = 1'b0;
    #1;
    check("rstmid_strobes", {25'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_d_oe},
          {25'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0});
    check("rstmid_resp_valid", {31'b0, mem_resp_valid}, 32'd0);
    check("rstmid_ready", {31'b0, mem_req_ready}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    issue(32'h8000_0010, 1'b0, 32'h0, 4'hF);
    wait_idle("rstmid_read");

    // Alternating write/read pairs with random data and byte enables
    for (int i = 0; i < 10; i++) begin
      a  = {10'h200, 20'($urandom), 2'b00};
      d  = $urandom;
      be = 4'($urandom);
      issue(a, 1'b1, d, be);
      issue(a, 1'b0, 32'h0, 4'hF);
    end
    wait_idle("pairs");

    check("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
